// File: rtl/dmem_controller.sv
// Round-robin front-end that shares the word-wide data_memory between the core
// load/store port (m0) and the word-only debug/DMA port (m1).
module dmem_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic              m0_unsigned,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state  | meaning
    // IDLE   | no access in flight, arbitrate and grant
    // ACCESS | memory addressed: load capture, word write, or RMW read
    // RMW_WR | write back merged word of a sub-word store
    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR} state_t;

    state_t            state_q;
    logic              ptr_q;
    logic              owner_q;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merged_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;

    logic              gnt0;
    logic              gnt1;
    logic              sub_word;
    logic              word_wr;
    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [DATA_W-1:0] load_d;
    logic [DATA_W-1:0] merged_d;

    // ptr_q = 0 favours m0 on a tie, 1 favours m1
    assign gnt0 = rst_n && (state_q == IDLE) && m0_req && (!m1_req || !ptr_q);
    assign gnt1 = rst_n && (state_q == IDLE) && m1_req && (!m0_req || ptr_q);

    assign sub_word = !size_q[1];
    assign word_wr  = (state_q == ACCESS) && we_q && !sub_word;

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

    assign mem_addr  = (state_q == IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_we    = word_wr || (state_q == RMW_WR);
    assign mem_wdata = (state_q == RMW_WR) ? merged_q : (word_wr ? wdata_q : '0);

    assign byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sh = mem_rdata >> {addr_q[1], 4'b0000};

    always_comb begin
        load_d   = mem_rdata;
        merged_d = mem_rdata;
        case (size_q)
            2'b00: begin
                load_d = {{(DATA_W-8){!uns_q && byte_sh[7]}}, byte_sh[7:0]};
                merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_d = {{(DATA_W-16){!uns_q && half_sh[15]}}, half_sh[15:0]};
                merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_d   = mem_rdata;
                merged_d = mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            merged_q    <= '0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner_q <= gnt1;
                        ptr_q   <= gnt0;
                        addr_q  <= gnt1 ? m1_addr  : m0_addr;
                        we_q    <= gnt1 ? m1_we    : m0_we;
                        wdata_q <= gnt1 ? m1_wdata : m0_wdata;
                        size_q  <= gnt1 ? 2'b10    : m0_size;
                        uns_q   <= gnt1 ? 1'b0     : m0_unsigned;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (owner_q) begin
                            m1_rdata_q  <= load_d;
                            m1_rvalid_q <= 1'b1;
                        end else begin
                            m0_rdata_q  <= load_d;
                            m0_rvalid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (sub_word) begin
                        merged_q <= merged_d;
                        state_q  <= RMW_WR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RMW_WR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_controller.sv
// Scoreboard bench for dmem_controller with a behavioural word memory attached.
module tb_dmem_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_unsigned;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m0_gnt, m0_rvalid;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] mem [0:1023];
    int          cyc = 0;
    int          wr_count = 0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    dmem_controller #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m0_rvalid) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL m0_rvalid_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                e0 = q0.pop_front();
                check("m0_rdata", m0_rdata, e0.data);
                check("m0_rvalid_cycle", cyc, e0.cyc);
            end
        end
        if (rst_n && m1_rvalid) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL m1_rvalid_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                e1 = q1.pop_front();
                check("m1_rdata", m1_rdata, e1.data);
                check("m1_rvalid_cycle", cyc, e1.cyc);
            end
        end
    end

    task automatic push_exp(input bit sel, input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        if (sel) q1.push_back(e);
        else     q0.push_back(e);
    endtask

    task automatic do_op(input bit sel, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, output int wait_cyc);
        bit got;
        @(posedge clk); #1;
        if (!sel) begin
            m0_req = 1'b1; m0_we = we; m0_size = size; m0_unsigned = uns;
            m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        got = 1'b0;
        wait_cyc = 0;
        while (!got && wait_cyc < 20) begin
            @(negedge clk);
            if (sel ? m1_gnt : m0_gnt) begin
                got = 1'b1;
                if (!we) push_exp(sel, exp_data, cyc + 2);
            end
            @(posedge clk); #1;
            if (!got) wait_cyc++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL grant_timeout: got no gnt for master %0d addr %h expected gnt", sel, addr);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int w;
    int wrc0;
    bit first_m1;
    logic [1:0] exp_g;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_size = 0; m0_unsigned = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        #3;
        check("reset_outputs", {31'b0, |{m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid,
              m1_rdata, mem_addr, mem_we, mem_wdata}}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(0, 1, 2'b10, 0, 32'h03C0, 32'h00005555, 0, w);
        check("mem_sw_03c0", mem[32'h03C0 >> 2], 32'h00005555);
        do_op(0, 0, 2'b10, 0, 32'h03C0, 0, 32'h00005555, w);

        do_op(1, 1, 2'b10, 0, 32'h0F0C, 32'h11223344, 0, w);
        wrc0 = wr_count;
        do_op(0, 1, 2'b00, 0, 32'h0F0D, 32'h000000AB, 0, w);
        check("sb_write_count", wr_count - wrc0, 1);
        check("mem_sb_0f0c", mem[32'h0F0C >> 2], 32'h1122AB44);
        do_op(0, 0, 2'b00, 0, 32'h0F0D, 0, 32'hFFFFFFAB, w);
        do_op(0, 0, 2'b00, 1, 32'h0F0D, 0, 32'h000000AB, w);

        do_op(1, 1, 2'b10, 0, 32'h0510, 32'h00000000, 0, w);
        do_op(0, 1, 2'b01, 0, 32'h0512, 32'h00008001, 0, w);
        check("mem_sh_0510", mem[32'h0510 >> 2], 32'h80010000);
        do_op(0, 0, 2'b01, 0, 32'h0512, 0, 32'hFFFF8001, w);
        do_op(0, 0, 2'b01, 1, 32'h0512, 0, 32'h00008001, w);
        do_op(1, 0, 2'b10, 0, 32'h0511, 0, 32'h80010000, w);

        do_op(0, 0, 2'b00, 0, 32'h0513, 0, 32'hFFFFFF80, w);
        do_op(0, 0, 2'b00, 1, 32'h0F0E, 0, 32'h00000022, w);
        do_op(0, 0, 2'b01, 0, 32'h0F0C, 0, 32'hFFFFAB44, w);
        do_op(0, 0, 2'b01, 0, 32'h0F0F, 0, 32'h00001122, w);
        do_op(0, 0, 2'b11, 0, 32'h0F0F, 0, 32'h1122AB44, w);
        do_op(0, 1, 2'b00, 0, 32'h0510, 32'h1234567F, 0, w);
        check("mem_sb_lane0", mem[32'h0510 >> 2], 32'h8001007F);

        // reset while an m0 load is in ACCESS
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_size = 2'b10; m0_unsigned = 0; m0_addr = 32'h03C0;
        @(negedge clk);
        check("rst_access_gnt", {31'b0, m0_gnt}, 32'h1);
        @(posedge clk); #1;
        m0_req = 0;
        check("rst_access_addr", mem_addr, 32'h03C0);
        rst_n = 1'b0;
        #1;
        check("rst_access_outputs", {31'b0, |{m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid,
              m1_rdata, mem_addr, mem_we, mem_wdata}}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // both masters hold req: grants alternate starting with m0
        m0_req = 1; m0_we = 0; m0_size = 2'b10; m0_addr = 32'h03C0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h0F0C;
        first_m1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                exp_g = (((i / 2) % 2 == 1) ^ first_m1) ? 2'b01 : 2'b10;
                if (exp_g == 2'b10) push_exp(0, 32'h00005555, cyc + 2);
                else                push_exp(1, 32'h1122AB44, cyc + 2);
            end else begin
                exp_g = 2'b00;
            end
            check("arb_gnt", {30'b0, m0_gnt, m1_gnt}, {30'b0, exp_g});
            @(posedge clk);
        end
        #1;
        m0_req = 0; m1_req = 0;

        do_op(0, 0, 2'b10, 0, 32'h03C0, 0, 32'h00005555, w);
        do_op(0, 0, 2'b10, 0, 32'h03C0, 0, 32'h00005555, w);
        check("lone_m0_immediate", w, 0);

        // reset while a byte store sits in RMW_WR
        wrc0 = wr_count;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 1; m0_size = 2'b00; m0_unsigned = 0;
        m0_addr = 32'h0F0C; m0_wdata = 32'h00000077;
        @(negedge clk);
        check("rmw_gnt", {31'b0, m0_gnt}, 32'h1);
        @(posedge clk); #1;
        m0_req = 0;
        check("rmw_access_we", {31'b0, mem_we}, 32'h0);
        @(posedge clk); #1;
        check("rmw_wr_we", {31'b0, mem_we}, 32'h1);
        check("rmw_wr_data", mem_wdata, 32'h1122AB77);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_we", {31'b0, mem_we}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rmw_rst_no_write", wr_count - wrc0, 0);
        do_op(0, 0, 2'b10, 0, 32'h0F0C, 0, 32'h1122AB44, w);

        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_controller.md
Name: dmem_controller

Overview:
Sequencing and arbitration front-end for the single-port word-wide data_memory. It shares the memory between the core load/store port (m0, byte/half/word) and a word-only debug/DMA port (m1) using round-robin arbitration. Sub-word stores are performed as a read-modify-write, because data_memory only writes full words. Its mem_* outputs connect directly to data_memory ALUResult/memwrite/write_data/read_data.

Parameters:
ADDR_W, 32, byte-address width of requester and memory addresses
DATA_W, 32, data width; fixed at 32, byte-lane logic assumes 4 lanes

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  core request; held with payload until m0_gnt
m0_we  input  1  1 = store, 0 = load
m0_size  input  2  00 byte, 01 half, 10/11 word
m0_unsigned  input  1  1 = zero-extend sub-word load, 0 = sign-extend
m0_addr  input  ADDR_W  byte address
m0_wdata  input  DATA_W  store data, right-aligned
m0_gnt  output  1  one-cycle accept pulse
m0_rvalid  output  1  one-cycle load-data-valid pulse
m0_rdata  output  DATA_W  extended load data, held until next m0 load
m1_req  input  1  debug/DMA word request
m1_we  input  1  1 = store, 0 = load
m1_addr  input  ADDR_W  byte address, addr[1:0] ignored
m1_wdata  input  DATA_W  store word
m1_gnt  output  1  one-cycle accept pulse
m1_rvalid  output  1  one-cycle load-data-valid pulse
m1_rdata  output  DATA_W  load word, held until next m1 load
mem_addr  output  ADDR_W  to data_memory ALUResult; always word-aligned
mem_we  output  1  to data_memory memwrite
mem_wdata  output  DATA_W  to data_memory write_data
mem_rdata  input  DATA_W  from data_memory read_data; combinational read

Behaviour:
- Reset (async, rst_n=0): state IDLE, priority pointer = m0, all outputs 0; latched request cleared.
- FSM states: IDLE, ACCESS, RMW_WR.
- IDLE: mem_we=0, mem_addr=0, mem_wdata=0. If any req is present, grant one master: mN_gnt=1 combinationally this cycle. On the edge, latch addr/we/size/unsigned/wdata/owner and go to ACCESS. If only one master requests, it wins. If both request, the pointer owner wins. The pointer then moves to the non-granted master.
- ACCESS: mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - Load: extract the lane from mem_rdata and register it into the owner's rdata. Owner's rvalid=1 the next cycle (IDLE). Next state IDLE.
  - Word store: mem_we=1, mem_wdata=wdata. Next state IDLE.
  - Sub-word store: mem_we=0. Register the merged word from mem_rdata. Next state RMW_WR.
- RMW_WR: mem_we=1, mem_wdata=merged word, same mem_addr. Next state IDLE.
- Latency: load rvalid at gnt cycle+2. Word store is written at the end of gnt+1. Sub-word store is written at the end of gnt+2. Stores produce no rvalid.
- A new grant may occur in the same IDLE cycle that rvalid pulses. Peak rate: 1 access per 2 cycles, 1 sub-word store per 3 cycles.
- Lane rules:
  - Byte: lane = addr[1:0]; bits [8*lane+7:8*lane].
  - Half: lane = addr[1]; bits [16*lane+15:16*lane]; addr[0] ignored.
  - Word: addr[1:0] ignored.
  - Sign extension from the lane MSB unless m0_unsigned=1. m1 is always word.
- Merge: replace only the addressed lane with wdata[7:0] or wdata[15:0]; other bytes keep the mem_rdata value.
- Requests arriving outside IDLE are not granted; requesters keep req high. A req dropped before gnt is simply never served.
- Reset mid-transaction: mem_we clears immediately, pending rvalid is lost, and pointer returns to m0. If reset is asserted before the RMW_WR edge, memory is unchanged.

Test Plan:
- Reset asserted during ACCESS of an m0 load -> all outputs 0 at once; after release, first simultaneous req grants m0.
- m0 SW addr 0x03C0 data 0x00005555, then m0 LW 0x03C0 -> m0_rvalid at gnt+2, m0_rdata=0x00005555.
- m1 SW 0x0F0C=0x11223344; m0 SB 0x0F0D data 0xAB -> one read then one write; word=0x1122AB44. LB 0x0F0D -> 0xFFFFFFAB; LBU -> 0x000000AB.
- m1 SW 0x0510=0; m0 SH 0x0512 data 0x8001 -> word 0x80010000. LH 0x0512 -> 0xFFFF8001; LHU -> 0x00008001; m1 LW 0x0511 -> 0x80010000.
- m0_req and m1_req held high continuously -> grants alternate m0,m1,m0,m1 exactly every 2 cycles for loads. With pointer at m1, a lone m0 req is granted immediately.
- Reset pulsed during RMW_WR of SB to 0x0F0C -> mem_we falls with rst_n; subsequent LW 0x0F0C returns the prior value 0x1122AB44.
